// File: rtl/gray2bin_sync.sv
// rtl/gray2bin_sync.sv - Gray-code bus synchronizer and registered decoder with step checking.
// Optional saturating error counter enabled by defining GRAY2BIN_ERR_CNT_EN.
module gray2bin_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             en,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             changed,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0] FILL_LOAD = FW'(SYNC_STAGES);
  localparam logic [FW-1:0] FILL_RUN  = FW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             step_err_q, step_err_d;

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] diff_m1;
  logic             acc;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gray_in};
  end

  // Running XOR from the MSB down gives each binary bit.
  always_comb begin
    dec = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ synced[i];
      dec[i] = acc;
    end
  end

  always_comb begin
    diff    = synced ^ prev_q;
    diff_m1 = diff - WIDTH'(1);
  end

  always_comb begin
    fill_d     = fill_q;
    prev_d     = prev_q;
    bin_d      = bin_q;
    valid_d    = valid_q;
    changed_d  = 1'b0;
    step_err_d = 1'b0;
    if (fill_q != FILL_RUN) begin
      fill_d = fill_q + FW'(1);
    end
    if (fill_q == FILL_LOAD) begin
      prev_d  = synced;
      bin_d   = dec;
      valid_d = 1'b1;
    end else if (fill_q == FILL_RUN && en) begin
      prev_d     = synced;
      bin_d      = dec;
      changed_d  = |diff;
      // Clearing the lowest set bit leaves something only when two or more bits differ.
      step_err_d = |(diff & diff_m1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      bin_q      <= '0;
      fill_q     <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      bin_q      <= bin_d;
      fill_q     <= fill_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      step_err_q <= step_err_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = valid_q;
  assign changed   = changed_q;
  assign step_err  = step_err_q;

`ifdef GRAY2BIN_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (step_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_gray2bin_sync.sv
// tb/tb_gray2bin_sync.sv - directed bench for gray2bin_sync (WIDTH=4, SYNC_STAGES=2).
module tb_gray2bin_sync;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       en;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       changed;
  logic       step_err;
  logic [7:0] err_cnt;

  int passed = 0;
  int total  = 0;

`ifdef GRAY2BIN_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  gray2bin_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .en        (en),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .changed   (changed),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] cnt_exp(input int n);
    return CNT_ON ? 8'(n) : 8'd0;
  endfunction

  initial begin
    rst_n   = 1'b0;
    gray_in = 4'b0110;
    en      = 1'b1;
    tick(3);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_valid", 32'(bin_valid), 32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_step_err", 32'(step_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    rst_n = 1'b1;
    tick(1);
    check("fill_e1_valid", 32'(bin_valid), 32'd0);
    tick(1);
    check("fill_e2_valid", 32'(bin_valid), 32'd0);
    tick(1);
    check("fill_e3_valid", 32'(bin_valid), 32'd1);
    check("fill_e3_bin", 32'(bin_out), 32'd4);
    check("fill_e3_changed", 32'(changed), 32'd0);
    check("fill_e3_step_err", 32'(step_err), 32'd0);

    rst_n   = 1'b0;
    gray_in = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("refill_valid", 32'(bin_valid), 32'd1);
    check("refill_bin", 32'(bin_out), 32'd0);

    for (int k = 1; k < 16; k++) begin
      logic [3:0] kb;
      kb = 4'(k);
      gray_in = kb ^ (kb >> 1);
      tick(2);
      check($sformatf("walk%0d_hold", k), 32'(bin_out), 32'(k - 1));
      check($sformatf("walk%0d_nochg", k), 32'(changed), 32'd0);
      tick(1);
      check($sformatf("walk%0d_bin", k), 32'(bin_out), 32'(k));
      check($sformatf("walk%0d_changed", k), 32'(changed), 32'd1);
      check($sformatf("walk%0d_step_err", k), 32'(step_err), 32'd0);
      tick(1);
      check($sformatf("walk%0d_pulse_end", k), 32'(changed), 32'd0);
    end
    check("walk_err_cnt", 32'(err_cnt), 32'd0);

    gray_in = 4'b0000;
    tick(3);
    check("wrap_bin", 32'(bin_out), 32'd0);
    check("wrap_changed", 32'(changed), 32'd1);
    check("wrap_step_err", 32'(step_err), 32'd0);
    tick(1);
    check("wrap_pulse_end", 32'(changed), 32'd0);

    gray_in = 4'b0011;
    tick(3);
    check("jump_bin", 32'(bin_out), 32'd2);
    check("jump_step_err", 32'(step_err), 32'd1);
    check("jump_changed", 32'(changed), 32'd1);
    check("jump_err_cnt", 32'(err_cnt), 32'(cnt_exp(1)));
    tick(1);
    check("jump_err_end", 32'(step_err), 32'd0);
    check("jump_chg_end", 32'(changed), 32'd0);

    gray_in = 4'b0001;
    tick(3);
    check("pre_hold_bin", 32'(bin_out), 32'd1);
    check("pre_hold_step_err", 32'(step_err), 32'd0);
    en      = 1'b0;
    gray_in = 4'b0011;
    tick(4);
    check("hold1_bin", 32'(bin_out), 32'd1);
    check("hold1_changed", 32'(changed), 32'd0);
    gray_in = 4'b0010;
    tick(4);
    check("hold2_bin", 32'(bin_out), 32'd1);
    check("hold2_step_err", 32'(step_err), 32'd0);
    en = 1'b1;
    tick(1);
    check("reen_bin", 32'(bin_out), 32'd3);
    check("reen_step_err", 32'(step_err), 32'd1);
    check("reen_changed", 32'(changed), 32'd1);
    check("reen_err_cnt", 32'(err_cnt), 32'(cnt_exp(2)));

    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick(1);
    end
    tick(4);
    check("sat_err_cnt", 32'(err_cnt), 32'(cnt_exp(255)));
    check("sat_step_err_quiet", 32'(step_err), 32'd0);
    check("sat_valid_sticky", 32'(bin_valid), 32'd1);

    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bin_valid), 32'd0);
    check("midrst_bin", 32'(bin_out), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    tick(1);
    rst_n   = 1'b1;
    gray_in = 4'b0101;
    tick(2);
    check("midrst_refill_valid", 32'(bin_valid), 32'd0);
    check("midrst_refill_chg", 32'(changed), 32'd0);
    tick(1);
    check("midrst_load_bin", 32'(bin_out), 32'd6);
    check("midrst_load_chg", 32'(changed), 32'd0);
    check("midrst_load_err", 32'(step_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
